// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit (Booth multiplier and
// non-restoring divider).
//   STATE_BITS     : width of the exported STATE port
//   state_t        : IDLE=0, BUSY=1, FIXUP=2 (the multiplier only uses IDLE/BUSY)
//   step_cnt_bits  : width of an iteration counter able to count 0..n
package arith_pkg;

  localparam int STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  function automatic int step_cnt_bits(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// One radix-2 non-restoring division iteration, purely combinational.
//   i_p      : signed partial remainder, W+1 bits
//   i_q      : quotient / dividend shift register, W bits
//   i_d      : divisor magnitude, W bits
//   o_p_next : partial remainder after shift and add/subtract
//   o_q_next : shift register after shift, new quotient bit in bit 0
module div_nr_step #(
  parameter int W = 32
) (
  input  logic [W:0]   i_p,
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_d,
  output logic [W:0]   o_p_next,
  output logic [W-1:0] o_q_next
);

  logic [W:0] w_p_sh;
  logic [W:0] w_p_new;

  // {P,Q} << 1. The MSB of P is dropped: the result after +/-D always lies
  // in [-D, D), which fits W+1 bits, so modulo arithmetic stays exact.
  assign w_p_sh  = {i_p[W-1:0], i_q[W-1]};
  assign w_p_new = i_p[W] ? (w_p_sh + {1'b0, i_d}) : (w_p_sh - {1'b0, i_d});

  assign o_p_next = w_p_new;
  assign o_q_next = {i_q[W-2:0], ~w_p_new[W]};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 non-restoring divider, one quotient bit per clock.
// Result after INPUT_BITS+1 edges from accept (1 edge for a zero divisor).
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (truncating division, remainder follows the dividend's sign).
//   CLK, RST_N         : clock, asynchronous active-low reset
//   DIV_1, DIV_2       : dividend, divisor
//   DIV_1/2_VALID      : operand valids, accepted only while STATE==IDLE
//   STATE              : IDLE / BUSY / FIXUP
//   QUOTIENT/REMAINDER : registered results, held until the next result
//   DIV_OUT_VALID      : one-cycle result pulse
//   DIV_BY_ZERO        : zero-divisor flag, valid with DIV_OUT_VALID
module seq_divider
  import arith_pkg::*;
#(
  parameter int INPUT_BITS = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [INPUT_BITS-1:0] DIV_1,
  input  logic [INPUT_BITS-1:0] DIV_2,
  input  logic                  DIV_1_VALID,
  input  logic                  DIV_2_VALID,
  output logic [STATE_BITS-1:0] STATE,
  output logic [INPUT_BITS-1:0] QUOTIENT,
  output logic [INPUT_BITS-1:0] REMAINDER,
  output logic                  DIV_OUT_VALID,
  output logic                  DIV_BY_ZERO
);

  localparam int N        = INPUT_BITS;
  localparam int CNT_BITS = step_cnt_bits(INPUT_BITS);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_BITS-1:0] r_cnt;
  logic [N:0]          r_p;
  logic [N-1:0]        r_q;
  logic [N-1:0]        r_d;
  logic                r_dbz_pend;
  logic [N-1:0]        r_quotient;
  logic [N-1:0]        r_remainder;
  logic                r_out_valid;
  logic                r_dbz;

  logic                w_accept;
  logic                w_div_zero;
  logic                w_last;
  logic [N-1:0]        w_mag1;
  logic [N-1:0]        w_mag2;
  logic [N:0]          w_p_step;
  logic [N-1:0]        w_q_step;
  logic [N:0]          w_p_fix;
  logic [N-1:0]        w_quo_fix;
  logic [N-1:0]        w_rem_fix;

  assign w_accept   = (r_state == IDLE) && DIV_1_VALID && DIV_2_VALID;
  assign w_div_zero = (DIV_2 == '0);
  assign w_last     = (r_cnt == CNT_BITS'(N - 1));

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // MIN has no positive counterpart, but -MIN == MIN reads correctly as an
  // unsigned magnitude, so no special case is needed.
  assign w_mag1 = DIV_1[N-1] ? (-DIV_1) : DIV_1;
  assign w_mag2 = DIV_2[N-1] ? (-DIV_2) : DIV_2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= DIV_1[N-1] ^ DIV_2[N-1];
      r_neg_r <= DIV_1[N-1];
    end
  end
`else
  assign w_mag1 = DIV_1;
  assign w_mag2 = DIV_2;
`endif

  div_nr_step #(
    .W (N)
  ) u_step (
    .i_p      (r_p),
    .i_q      (r_q),
    .i_d      (r_d),
    .o_p_next (w_p_step),
    .o_q_next (w_q_step)
  );

  // Final correction of a negative partial remainder, then sign restore.
  assign w_p_fix = r_p[N] ? (r_p + {1'b0, r_d}) : r_p;

  always_comb begin
    w_quo_fix = r_q;
    w_rem_fix = w_p_fix[N-1:0];
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (r_neg_q) w_quo_fix = -r_q;
    if (r_neg_r) w_rem_fix = -w_p_fix[N-1:0];
`endif
    // Zero divisor: r_q holds the raw dividend, returned unchanged.
    if (r_dbz_pend) begin
      w_quo_fix = '1;
      w_rem_fix = r_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_div_zero ? FIXUP : BUSY;
      BUSY:    if (w_last)   w_state_next = FIXUP;
      FIXUP:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt       <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_dbz_pend  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_out_valid <= (r_state == FIXUP);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt      <= '0;
            r_p        <= '0;
            r_d        <= w_mag2;
            r_dbz_pend <= w_div_zero;
            // On a zero divisor no iteration runs, so the shift register
            // carries the raw dividend straight to the remainder output.
            r_q        <= w_div_zero ? DIV_1 : w_mag1;
          end
        end
        BUSY: begin
          r_p   <= w_p_step;
          r_q   <= w_q_step;
          r_cnt <= r_cnt + 1'b1;
        end
        FIXUP: begin
          r_quotient  <= w_quo_fix;
          r_remainder <= w_rem_fix;
          r_dbz       <= r_dbz_pend;
        end
        default: ;
      endcase
    end
  end

  assign STATE         = r_state;
  assign QUOTIENT      = r_quotient;
  assign REMAINDER     = r_remainder;
  assign DIV_OUT_VALID = r_out_valid;
  assign DIV_BY_ZERO   = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at INPUT_BITS=8.
module tb_seq_divider;

  localparam int N = 8;

  logic         CLK;
  logic         RST_N;
  logic [N-1:0] DIV_1;
  logic [N-1:0] DIV_2;
  logic         DIV_1_VALID;
  logic         DIV_2_VALID;
  logic [1:0]   STATE;
  logic [N-1:0] QUOTIENT;
  logic [N-1:0] REMAINDER;
  logic         DIV_OUT_VALID;
  logic         DIV_BY_ZERO;

  int checks   = 0;
  int failures = 0;

  seq_divider #(
    .INPUT_BITS (N)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .DIV_1         (DIV_1),
    .DIV_2         (DIV_2),
    .DIV_1_VALID   (DIV_1_VALID),
    .DIV_2_VALID   (DIV_2_VALID),
    .STATE         (STATE),
    .QUOTIENT      (QUOTIENT),
    .REMAINDER     (REMAINDER),
    .DIV_OUT_VALID (DIV_OUT_VALID),
    .DIV_BY_ZERO   (DIV_BY_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: present operands for one accept edge, wait for the
  // result pulse (bounded), check latency, results, flag and pulse width.
  task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic edbz);
    int lat;
    int exp_lat;
    exp_lat = (b == 0) ? 1 : N + 1;
    @(negedge CLK);
    DIV_1 = a; DIV_2 = b; DIV_1_VALID = 1'b1; DIV_2_VALID = 1'b1;
    @(posedge CLK); #1;
    DIV_1_VALID = 1'b0; DIV_2_VALID = 1'b0;
    check({tag, "_state_after_accept"}, 32'(STATE), (b == 0) ? 32'd2 : 32'd1);
    lat = 0;
    while (!DIV_OUT_VALID && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_q"}, 32'(QUOTIENT), 32'(eq));
    check({tag, "_r"}, 32'(REMAINDER), 32'(er));
    check({tag, "_dbz"}, 32'(DIV_BY_ZERO), 32'(edbz));
    check({tag, "_state_idle"}, 32'(STATE), 32'd0);
    @(posedge CLK); #1;
    check({tag, "_valid_pulse_end"}, 32'(DIV_OUT_VALID), 32'd0);
    $display("div %s: %0d / %0d -> q=0x%0h r=0x%0h dbz=%0d lat=%0d",
             tag, a, b, QUOTIENT, REMAINDER, DIV_BY_ZERO, lat);
  endtask

  function automatic logic [N-1:0] op_a(input int i);
    return N'(2 + i * 4);
  endfunction

  function automatic logic [N-1:0] op_b(input int i);
    return N'((i % 5) + 1);
  endfunction

  initial begin
    logic [N-1:0] ea;
    logic [N-1:0] eb;
    int pulses;

    RST_N = 1'b0;
    DIV_1 = '0; DIV_2 = '0; DIV_1_VALID = 1'b0; DIV_2_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 32'(STATE), 32'd0);
    check("reset_q", 32'(QUOTIENT), 32'd0);
    check("reset_r", 32'(REMAINDER), 32'd0);
    check("reset_valid", 32'(DIV_OUT_VALID), 32'd0);
    check("reset_dbz", 32'(DIV_BY_ZERO), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("s_m100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
    run_div("s_100_m7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
    run_div("s_min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
`endif

    run_div("d55_0", 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1);
    run_div("d20_4", 8'd20, 8'd4, 8'd5, 8'd0, 1'b0);

    run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    run_div("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    // 0xFF/1 and 0xFF/0xFF give the same bits in both builds (-1/1, -1/-1).
    run_div("d255_1", 8'hFF, 8'd1, 8'hFF, 8'd0, 1'b0);
    run_div("d255_255", 8'hFF, 8'hFF, 8'd1, 8'd0, 1'b0);

    // Asynchronous reset in the middle of 200/3.
    @(negedge CLK);
    DIV_1 = 8'd200; DIV_2 = 8'd3; DIV_1_VALID = 1'b1; DIV_2_VALID = 1'b1;
    @(posedge CLK); #1;
    DIV_1_VALID = 1'b0; DIV_2_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check("arst_state", 32'(STATE), 32'd0);
    check("arst_q", 32'(QUOTIENT), 32'd0);
    check("arst_r", 32'(REMAINDER), 32'd0);
    check("arst_valid", 32'(DIV_OUT_VALID), 32'd0);
    check("arst_dbz", 32'(DIV_BY_ZERO), 32'd0);
    $display("async reset asserted mid-operation: state=%0d q=0x%0h r=0x%0h", STATE, QUOTIENT, REMAINDER);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (DIV_OUT_VALID) pulses++;
    end
    check("arst_no_pulse", 32'(pulses), 32'd0);
    check("arst_idle_after", 32'(STATE), 32'd0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("d200_3_after_rst", 8'd200, 8'd3, 8'hEE, 8'hFE, 1'b0);
`else
    run_div("d200_3_after_rst", 8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
`endif

    // Valids held high with operands changing every cycle: accepts happen
    // at edges 0, 10, 20; results at edges 9, 19, 29.
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      DIV_1 = op_a(i); DIV_2 = op_b(i); DIV_1_VALID = 1'b1; DIV_2_VALID = 1'b1;
      @(posedge CLK); #1;
      if (i % 10 == 9) begin
        ea = op_a(i - 9);
        eb = op_b(i - 9);
        check($sformatf("stream%0d_valid", i), 32'(DIV_OUT_VALID), 32'd1);
        check($sformatf("stream%0d_q", i), 32'(QUOTIENT), 32'(ea / eb));
        check($sformatf("stream%0d_r", i), 32'(REMAINDER), 32'(ea % eb));
        $display("stream result at edge %0d: %0d / %0d -> q=%0d r=%0d", i, ea, eb, QUOTIENT, REMAINDER);
      end else begin
        check($sformatf("stream%0d_novalid", i), 32'(DIV_OUT_VALID), 32'd0);
      end
      if (DIV_OUT_VALID) pulses++;
    end
    @(negedge CLK);
    DIV_1_VALID = 1'b0; DIV_2_VALID = 1'b0;
    check("stream_pulses", 32'(pulses), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
